psram_responder: RTL and testbench



---
 rtl/psram_responder_if.sv | 28 ++
 rtl/psram_responder.sv | 180 ++++++++++++++++++
 tb/tb_psram_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/psram_responder_if.sv
// Memory-pin bundle between a PSRAM controller (master) and the responder (slave).
// The bidirectional data bus is split into controller-driven and responder-driven halves.
interface psram_responder_if;
  logic        RamCS;
  logic        MemOE;
  logic        MemWR;
  logic        RamCRE;
  logic        RamUB;
  logic        RamLB;
  logic        MemAdv;
  logic        MemClk;
  logic [22:0] MemAdr;
  logic [15:0] MemDB_in;
  logic [15:0] MemDB_out;
  logic        MemDB_oe;
  logic [15:0] bcr;
  logic        err;

  modport master (
    output RamCS, MemOE, MemWR, RamCRE, RamUB, RamLB, MemAdv, MemClk, MemAdr, MemDB_in,
    input  MemDB_out, MemDB_oe, bcr, err
  );

  modport slave (
    input  RamCS, MemOE, MemWR, RamCRE, RamUB, RamLB, MemAdv, MemClk, MemAdr, MemDB_in,
    output MemDB_out, MemDB_oe, bcr, err
  );
endinterface

// File: rtl/psram_responder.sv
// Fixed-latency asynchronous-mode cellular PSRAM model answering a controller from an
// on-chip 16-bit word array; all pin inputs are registered once before use.
module psram_responder #(
  parameter int          ADDR_W   = 10,
  parameter int          READ_LAT = 4,
  parameter logic [15:0] BCR_RST  = 16'h9D1F
) (
  input  logic             clk,
  input  logic             reset_n,
  psram_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE, CFG} state_t;
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  logic        cs_q, oe_q, wr_q, cre_q, ub_q, lb_q, mclk_q;
  logic [22:0] adr_q;
  logic [15:0] din_q;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [22:0] addr_l_q, addr_l_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ub_l_q, ub_l_d, lb_l_q, lb_l_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_out_q, oe_out_d;
  logic [15:0] bcr_q, bcr_d;
  logic        err_q, err_d;
  logic        mem_we, rearm;
  logic        unused_adv;

  logic [15:0] mem [2**ADDR_W];

  // A byte lane whose (active-low) enable is high reads back as zero.
  function automatic logic [15:0] lane_mask(input logic [15:0] w, input logic ub, input logic lb);
    return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
  endfunction

  assign unused_adv = bus.MemAdv;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_l_d = addr_l_q;
    wdata_d  = wdata_q;
    ub_l_d   = ub_l_q;
    lb_l_d   = lb_l_q;
    dout_d   = dout_q;
    oe_out_d = oe_out_q;
    bcr_d    = bcr_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    rearm    = 1'b0;

    if (!cs_q && mclk_q) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!cs_q && !wr_q) begin
          addr_l_d = adr_q;
          if (!oe_q) err_d = 1'b1;
          if (cre_q) begin
            state_d = CFG;
          end else begin
            state_d = WRITE;
            wdata_d = din_q;
            ub_l_d  = ub_q;
            lb_l_d  = lb_q;
          end
        end else if (!cs_q && !oe_q) begin
          rearm = 1'b1;
        end
      end
      WRITE: begin
        if (cs_q || wr_q) begin
          mem_we  = 1'b1;
          state_d = IDLE;
        end else begin
          wdata_d = din_q;
          ub_l_d  = ub_q;
          lb_l_d  = lb_q;
        end
      end
      CFG: begin
        if (cs_q || wr_q) begin
          if (addr_l_q[19:18] == 2'b10) bcr_d = addr_l_q[15:0];
          else                          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      READ_WAIT, READ_DRIVE: begin
        if (!cs_q && !wr_q) begin
          state_d  = IDLE;
          oe_out_d = 1'b0;
          err_d    = 1'b1;
        end else if (cs_q || oe_q) begin
          state_d  = IDLE;
          oe_out_d = 1'b0;
        end else if (adr_q != addr_l_q) begin
          rearm = 1'b1;
        end else if (state_q == READ_DRIVE) begin
          dout_d = lane_mask(mem[addr_l_q[ADDR_W-1:0]], ub_q, lb_q);
        end else begin
          // Counter reaches zero on the edge that starts driving.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d  = READ_DRIVE;
            oe_out_d = 1'b1;
            dout_d   = lane_mask(mem[addr_l_q[ADDR_W-1:0]], ub_q, lb_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // New access time: the FSM edge that latches the address counts as the first latency cycle.
    if (rearm) begin
      addr_l_d = adr_q;
      cnt_d    = LAT_M1;
      if (READ_LAT == 1) begin
        state_d  = READ_DRIVE;
        oe_out_d = 1'b1;
        dout_d   = lane_mask(mem[adr_q[ADDR_W-1:0]], ub_q, lb_q);
      end else begin
        state_d  = READ_WAIT;
        oe_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q     <= 1'b1;
      oe_q     <= 1'b1;
      wr_q     <= 1'b1;
      cre_q    <= 1'b0;
      ub_q     <= 1'b1;
      lb_q     <= 1'b1;
      mclk_q   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      oe_out_q <= 1'b0;
      bcr_q    <= BCR_RST;
      err_q    <= 1'b0;
    end else begin
      cs_q     <= bus.RamCS;
      oe_q     <= bus.MemOE;
      wr_q     <= bus.MemWR;
      cre_q    <= bus.RamCRE;
      ub_q     <= bus.RamUB;
      lb_q     <= bus.RamLB;
      mclk_q   <= bus.MemClk;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      oe_out_q <= oe_out_d;
      bcr_q    <= bcr_d;
      err_q    <= err_d;
    end
  end

  // Datapath and array carry no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    adr_q    <= bus.MemAdr;
    din_q    <= bus.MemDB_in;
    addr_l_q <= addr_l_d;
    wdata_q  <= wdata_d;
    ub_l_q   <= ub_l_d;
    lb_l_q   <= lb_l_d;
    if (mem_we) begin
      if (!ub_l_q) mem[addr_l_q[ADDR_W-1:0]][15:8] <= wdata_q[15:8];
      if (!lb_l_q) mem[addr_l_q[ADDR_W-1:0]][7:0]  <= wdata_q[7:0];
    end
  end

  assign bus.MemDB_out = dout_q;
  assign bus.MemDB_oe  = oe_out_q;
  assign bus.bcr       = bcr_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_psram_responder.sv
// Bench for psram_responder: vector table of writes/reads scored through an expected-data
// queue, plus hand-written sequences for address change, config, violations and reset.
module tb_psram_responder;
  localparam int READ_LAT = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  psram_responder_if b();

  psram_responder #(.ADDR_W(10), .READ_LAT(READ_LAT), .BCR_RST(16'h9D1F)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [22:0] adr;
    logic [15:0] data;
    logic        ub;
    logic        lb;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [17];
  logic [15:0] sbq [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_pins();
    b.RamCS = 1'b1; b.MemOE = 1'b1; b.MemWR = 1'b1; b.RamCRE = 1'b0;
    b.RamUB = 1'b1; b.RamLB = 1'b1; b.MemClk = 1'b0; b.MemAdv = 1'b1;
  endtask

  // Counts rising edges until MemDB_oe equals val, sampling 1 time unit after each edge.
  task automatic wait_oe(input logic val, input int lim, output int k);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk); #1;
      if (b.MemDB_oe === val) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [22:0] adr, input logic [15:0] data,
                          input logic ub, input logic lb, input logic oe_low);
    @(negedge clk);
    b.RamCS = 1'b0; b.MemWR = 1'b0; b.MemOE = oe_low ? 1'b0 : 1'b1; b.RamCRE = 1'b0;
    b.MemAdr = adr; b.MemDB_in = data; b.RamUB = ub; b.RamLB = lb;
    repeat (3) @(negedge clk);
    idle_pins();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_cfg(input logic [22:0] adr);
    @(negedge clk);
    b.RamCS = 1'b0; b.MemWR = 1'b0; b.RamCRE = 1'b1; b.MemAdr = adr;
    repeat (2) @(negedge clk);
    idle_pins();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input logic [22:0] adr, input logic ub, input logic lb,
                         input logic mclk, input logic [15:0] exp, input string nm);
    int k;
    logic [15:0] e;
    @(negedge clk);
    b.RamCS = 1'b0; b.MemOE = 1'b0; b.MemWR = 1'b1; b.RamCRE = 1'b0;
    b.MemAdr = adr; b.RamUB = ub; b.RamLB = lb; b.MemClk = mclk;
    sbq.push_back(exp);
    @(posedge clk);
    wait_oe(1'b1, 20, k);
    e = sbq.pop_front();
    check({nm, "_lat"}, k, READ_LAT);
    check({nm, "_data"}, b.MemDB_out, e);
  endtask

  task automatic end_read(input string nm);
    @(negedge clk);
    idle_pins();
    repeat (2) @(posedge clk);
    #1 check({nm, "_release_oe"}, b.MemDB_oe, 1'b0);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    idle_pins();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, k1;
    vecs[0]  = '{0, 23'h000012, 16'hA55A, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1, 23'h000012, 16'h0000, 1'b0, 1'b0, 16'hA55A};
    vecs[2]  = '{0, 23'h000020, 16'h1234, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{0, 23'h000020, 16'hFFFF, 1'b0, 1'b1, 16'h0000};
    vecs[4]  = '{1, 23'h000020, 16'h0000, 1'b0, 1'b0, 16'hFF34};
    vecs[5]  = '{1, 23'h000020, 16'h0000, 1'b1, 1'b0, 16'h0034};
    vecs[6]  = '{1, 23'h000020, 16'h0000, 1'b0, 1'b1, 16'hFF00};
    vecs[7]  = '{0, 23'h000400, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1, 23'h000000, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
    vecs[9]  = '{0, 23'h7FFFFF, 16'hC3C3, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1, 23'h0003FF, 16'h0000, 1'b0, 1'b0, 16'hC3C3};
    vecs[11] = '{0, 23'h000030, 16'h0F0F, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{0, 23'h000030, 16'hFFFF, 1'b1, 1'b1, 16'h0000};
    vecs[13] = '{1, 23'h000030, 16'h0000, 1'b0, 1'b0, 16'h0F0F};
    vecs[14] = '{0, 23'h000040, 16'h1111, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{0, 23'h000041, 16'h2222, 1'b0, 1'b0, 16'h0000};
    vecs[16] = '{1, 23'h7FFC40, 16'h0000, 1'b0, 1'b0, 16'h1111};

    idle_pins();
    b.MemAdr = '0; b.MemDB_in = '0;
    repeat (3) @(negedge clk);
    check("rst_oe",  b.MemDB_oe,  1'b0);
    check("rst_out", b.MemDB_out, 16'h0000);
    check("rst_bcr", b.bcr,       16'h9D1F);
    check("rst_err", b.err,       1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].is_rd) begin
        do_read(vecs[i].adr, vecs[i].ub, vecs[i].lb, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));
        end_read($sformatf("vec%0d", i));
      end else begin
        do_write(vecs[i].adr, vecs[i].data, vecs[i].ub, vecs[i].lb, 1'b0);
      end
    end

    // Address change mid-drive, then a byte-enable change while driving.
    do_read(23'h000040, 1'b0, 1'b0, 1'b0, 16'h1111, "achg_first");
    @(negedge clk);
    b.MemAdr = 23'h000041;
    sbq.push_back(16'h2222);
    @(posedge clk);
    wait_oe(1'b0, 8, k0);
    check("achg_drop", k0, 1);
    wait_oe(1'b1, 20, k1);
    check("achg_lat", k0 + k1, READ_LAT);
    check("achg_data", b.MemDB_out, sbq.pop_front());
    @(negedge clk);
    b.RamUB = 1'b1;
    @(posedge clk); #1 check("be_hold", b.MemDB_out, 16'h2222);
    @(posedge clk); #1 check("be_update", b.MemDB_out, 16'h0022);
    end_read("achg");
    check("clean_err", b.err, 1'b0);

    // Configuration register writes.
    do_cfg(23'h081D1F);
    check("cfg_ok_bcr", b.bcr, 16'h1D1F);
    check("cfg_ok_err", b.err, 1'b0);
    do_cfg(23'h00ABCD);
    check("cfg_bad_bcr", b.bcr, 16'h1D1F);
    check("cfg_bad_err", b.err, 1'b1);

    // OE and WR low together: write still happens, error flagged.
    pulse_reset();
    check("rst2_bcr", b.bcr, 16'h9D1F);
    check("rst2_err", b.err, 1'b0);
    do_write(23'h000050, 16'h7777, 1'b0, 1'b0, 1'b1);
    check("oewr_err", b.err, 1'b1);
    do_read(23'h000050, 1'b0, 1'b0, 1'b0, 16'h7777, "oewr_rd");
    end_read("oewr_rd");

    // MemClk high during an access: flagged, access still completes.
    pulse_reset();
    do_read(23'h000050, 1'b0, 1'b0, 1'b1, 16'h7777, "mclk_rd");
    end_read("mclk_rd");
    check("mclk_err", b.err, 1'b1);

    // WR falling during a read aborts it without writing.
    pulse_reset();
    b.MemDB_in = 16'hDEAD;
    do_read(23'h000012, 1'b0, 1'b0, 1'b0, 16'hA55A, "abort_rd");
    @(negedge clk);
    b.MemWR = 1'b0;
    @(negedge clk);
    idle_pins();
    @(posedge clk); #1;
    check("abort_oe",  b.MemDB_oe, 1'b0);
    check("abort_err", b.err,      1'b1);
    do_read(23'h000012, 1'b0, 1'b0, 1'b0, 16'hA55A, "abort_nowr");

    // Reset while driving drops the bus without waiting for a clock.
    #2 reset_n = 1'b0;
    #1 check("rst_async_oe", b.MemDB_oe, 1'b0);
    idle_pins();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset in the middle of a write: no commit.
    @(negedge clk);
    b.RamCS = 1'b0; b.MemWR = 1'b0; b.MemAdr = 23'h000012; b.MemDB_in = 16'h0BAD;
    b.RamUB = 1'b0; b.RamLB = 1'b0;
    repeat (3) @(negedge clk);
    pulse_reset();
    do_read(23'h000012, 1'b0, 1'b0, 1'b0, 16'hA55A, "rstwr_rd");
    end_read("rstwr_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
